// File: rtl/sdram_port_arbiter.sv
// Shares the single 8-bit SDRAM port between download, Z80 RAM and cassette fetch.
// One access at a time, dl > cpu > cas, with a starvation guard lifting cas over cpu.
module sdram_port_arbiter #(
  parameter int AW           = 18,
  parameter int CAS_MAX_WAIT = 64,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          dl_req,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  output logic          dl_ack,
  output logic          dl_wait,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_ack,
  input  logic          cas_req,
  input  logic [AW-1:0] cas_addr,
  output logic [7:0]    cas_rdata,
  output logic          cas_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ack,
  output logic [1:0]    grant,
  output logic          timeout_err
);

  localparam int SW = $clog2(CAS_MAX_WAIT + 1);
  localparam int WW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_DL = 2'd1, OWN_CPU = 2'd2, OWN_CAS = 2'd3} owner_t;

  typedef struct packed {
    owner_t        owner;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
  } acc_t;

  state_t        state, state_nxt;
  acc_t          acc, pick;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;
  logic          cas_starved, timed_out, own_reads;
  logic [7:0]    rd_byte;

  assign cas_starved = (starve_cnt == SW'(CAS_MAX_WAIT));
  assign timed_out   = (wait_cnt == WW'(ACK_TIMEOUT - 1));
  assign own_reads   = (acc.owner == OWN_CAS) || (acc.owner == OWN_CPU && !acc.we);
  assign rd_byte     = mem_ack ? mem_rdata : 8'hFF;

  // Winner of the next IDLE decision; OWN_NONE when nobody asks.
  always_comb begin
    pick = '0;
    if (dl_req)
      pick = '{owner: OWN_DL, we: 1'b1, addr: dl_addr, wdata: dl_data};
    else if (cas_req && (cas_starved || !cpu_req))
      pick = '{owner: OWN_CAS, we: 1'b0, addr: cas_addr, wdata: 8'h00};
    else if (cpu_req)
      pick = '{owner: OWN_CPU, we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    dl_ack    = 1'b0;
    cpu_ack   = 1'b0;
    cas_ack   = 1'b0;
    case (state)
      IDLE:  if (pick.owner != OWN_NONE) state_nxt = ISSUE;
      ISSUE: begin
        mem_req   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:  if (mem_ack || timed_out) state_nxt = DONE;
      DONE: begin
        dl_ack    = (acc.owner == OWN_DL);
        cpu_ack   = (acc.owner == OWN_CPU);
        cas_ack   = (acc.owner == OWN_CAS);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_we    = mem_req & acc.we;
  assign mem_addr  = acc.addr;
  assign mem_wdata = acc.wdata;
  assign grant     = acc.owner;
  assign dl_wait   = dl_req & ~dl_ack;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc         <= '0;
      starve_cnt  <= '0;
      wait_cnt    <= '0;
      cpu_rdata   <= 8'h00;
      cas_rdata   <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      // Only IDLE decisions count as lost arbitrations.
      if (!cas_req)
        starve_cnt <= '0;
      else if (state == IDLE) begin
        if (pick.owner == OWN_CAS) starve_cnt <= '0;
        else if (!cas_starved)     starve_cnt <= starve_cnt + SW'(1);
      end

      case (state)
        IDLE:  acc <= pick;
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + WW'(1);
          if (mem_ack || timed_out) begin
            if (!mem_ack) timeout_err <= 1'b1;
            if (own_reads && acc.owner == OWN_CPU) cpu_rdata <= rd_byte;
            if (own_reads && acc.owner == OWN_CAS) cas_rdata <= rd_byte;
          end
        end
        DONE:  acc <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single 8-bit SDRAM port between three requesters: HPS ROM/cartridge download (write-only), the Z80 RAM path after the mapper (read/write), and the cassette reader's byte fetch (read-only).
- Sits between those requesters and the sdram controller.
- Sequences one access at a time using fixed priority plus a starvation guard for the cassette reader.
- Reports a sticky error if the SDRAM never acknowledges.

Parameters:
AW, 18, address width of all ports
CAS_MAX_WAIT, 64, lost arbitrations after which cas outranks cpu
ACK_TIMEOUT, 255, WAIT cycles before an access is aborted

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
dl_req  in  1  download write request, level, held until dl_ack
dl_addr  in  AW  download address
dl_data  in  8  download write data
dl_ack  out  1  one-cycle completion pulse
dl_wait  out  1  high while dl_req is high and dl_ack has not pulsed (drives ioctl_wait)
cpu_req  in  1  CPU request, level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  mapped CPU address
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  registered CPU read data
cpu_ack  out  1  one-cycle completion pulse
cas_req  in  1  cassette read request, level, held until cas_ack
cas_addr  in  AW  cassette byte address
cas_rdata  out  8  registered cassette read data
cas_ack  out  1  one-cycle completion pulse
mem_req  out  1  one-cycle access strobe to SDRAM
mem_we  out  1  write qualifier, valid with mem_req
mem_addr  out  AW  registered address
mem_wdata  out  8  registered write data
mem_rdata  in  8  SDRAM read data, valid with mem_ack
mem_ack  in  1  SDRAM completion pulse
grant  out  2  owner of current access: 0 none, 1 dl, 2 cpu, 3 cas
timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0, including rdata registers, grant, timeout_err, and the starvation counter. Reset mid-access abandons the access with no ack.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - Samples requests; the winner's address, data and write flag are latched and grant is set.
  - No request: stay in IDLE, grant=0.
- Priority: dl > cpu > cas. Exception: cas > cpu when starve_cnt == CAS_MAX_WAIT. dl always wins.
- Starvation counter (starve_cnt):
  - Increments in each IDLE decision where cas_req=1 and cas loses; saturates at CAS_MAX_WAIT.
  - Cleared when cas is granted or when cas_req=0.
- ISSUE: mem_req=1 for exactly one cycle. mem_we=1 for dl or for cpu with cpu_we=1; mem_we=0 for cas. Next state WAIT.
- WAIT:
  - On mem_ack: latch mem_rdata into the owner's rdata register (cpu reads and cas only; cpu writes and dl leave rdata unchanged), then go to DONE.
  - mem_ack is ignored in every state other than WAIT.
  - Wait counter increments each WAIT cycle. On reaching ACK_TIMEOUT without mem_ack: set timeout_err=1, load 8'hFF as read data, go to DONE.
- DONE: owner's ack=1 for one cycle, grant cleared, next state IDLE.
- Requester contract: deassert req on the clock edge where ack is sampled high. Address and data are stable while req=1. The arbiter does not re-sample a request in its own DONE cycle.
- Latency: a request high at IDLE edge T gives mem_req at T+1. With mem_ack in the first WAIT cycle (T+2), ack is at T+3. Back-to-back accesses take 4 cycles each.
- Simultaneous events:
  - dl_req rising while a cpu access is in WAIT: the cpu access completes first, then dl wins at the next IDLE.
  - All three requests high together: order is dl, cpu, cas (or dl, cas, cpu when cas is starved).
- dl_wait is combinational: dl_req & ~dl_ack.
- timeout_err is cleared only by reset.

Test Plan:
- Single cpu read: cpu_req=1, cpu_we=0, cpu_addr=18'h00100; memory model acks one cycle after mem_req with 8'h5A -> mem_req at T+1 with mem_we=0, cpu_ack at T+3, cpu_rdata=8'h5A, grant=2 during the access.
- Contention: dl_req and cpu_req rise in the same cycle (dl_addr=18'h20000, dl_data=8'hC3) -> dl served first (mem_we=1, mem_wdata=8'hC3), then cpu. dl_wait stays high until dl_ack.
- Starvation: cpu_req held continuously with CAS_MAX_WAIT=4 and cas_req=1 -> cas is granted after exactly 4 lost arbitrations, ahead of the pending cpu request; starve_cnt returns to 0.
- Timeout: with ACK_TIMEOUT=8, memory model never acks a cas read -> after 8 WAIT cycles cas_ack=1, cas_rdata=8'hFF, timeout_err=1 and held until reset.
- Reset mid-access: drop reset_n during WAIT -> all outputs 0 immediately, no ack pulse; after release, a fresh cpu request completes normally.
- Stray ack: pulse mem_ack while in IDLE -> no state change, no ack outputs, rdata registers unchanged.
